// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-k counter family.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    // Saturating add on up to 32-bit quantities; result never exceeds max_v.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_v}) begin
            return max_v;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/counter_sat.sv
// Saturating event counter: increments on i_inc, sticks at 2^M-1.
module counter_sat
    import counter_pkg::*;
#(
    parameter int unsigned M = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_inc,
    output logic [M-1:0] o_value
);

    localparam logic [31:0] MAX_V = (M >= 32) ? 32'hFFFF_FFFF
                                              : 32'((64'd1 << M) - 64'd1);

    logic [M-1:0] value_q;
    logic [M-1:0] value_d;
    logic [31:0]  sum;

    always_comb begin
        sum     = sat_add(32'(value_q), 32'd1, MAX_V);
        value_d = value_q;
        if (i_inc) begin
            value_d = sum[M-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign o_value = value_q;

endmodule

// File: rtl/counter_mod_k_updown.sv
// Up/down modulo-k counter with load, wrap pulse and saturating period count.
// The modulus is captured only on wrap or load so a running period is never cut short.
module counter_mod_k_updown
    import counter_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned M = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_en,
    input  logic         i_up,
    input  logic         i_load,
    input  logic [N-1:0] i_load_value,
    input  logic [N-1:0] i_k,
    output logic [N-1:0] o_count,
    output logic         o_wrap,
    output logic [M-1:0] o_periods,
    output logic [N-1:0] o_k_active
);

    // Raw modulus encoding 0 stands for 2^N, so widen to N+1 bits.
    function automatic logic [N:0] ext_k(input logic [N-1:0] k);
        return (k == '0) ? {1'b1, {N{1'b0}}} : {1'b0, k};
    endfunction

    logic [N-1:0] count_q, count_d;
    logic [N-1:0] k_q, k_d;
    logic         k_valid_q, k_valid_d;
    logic         wrap_q, wrap_d;

    logic [N-1:0] k_eff;
    logic [N:0]   k_eff_ext;
    logic [N:0]   last_ext;
    logic [N:0]   new_last_ext;
    logic [N:0]   count_ext;
    dir_t         dir;

    assign dir          = dir_t'(i_up);
    assign k_eff        = k_valid_q ? k_q : i_k;
    assign k_eff_ext    = ext_k(k_eff);
    assign last_ext     = k_eff_ext - 1'b1;
    assign new_last_ext = ext_k(i_k) - 1'b1;
    assign count_ext    = {1'b0, count_q};

    always_comb begin
        count_d   = count_q;
        k_d       = k_q;
        k_valid_d = k_valid_q;
        wrap_d    = 1'b0;
        if (i_load) begin
            count_d   = ({1'b0, i_load_value} > new_last_ext) ? new_last_ext[N-1:0]
                                                              : i_load_value;
            k_d       = i_k;
            k_valid_d = 1'b1;
        end else if (i_en) begin
            if (dir == DIR_UP) begin
                if (count_ext >= last_ext) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + N'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = last_ext[N-1:0];
                    wrap_d  = 1'b1;
                end else if (count_ext >= k_eff_ext) begin
                    count_d = last_ext[N-1:0];
                end else begin
                    count_d = count_q - N'(1);
                end
            end
            if (wrap_d) begin
                k_d       = i_k;
                k_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q   <= '0;
            k_q       <= '0;
            k_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            k_q       <= k_d;
            k_valid_q <= k_valid_d;
            wrap_q    <= wrap_d;
        end
    end

    counter_sat #(.M(M)) u_periods (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (wrap_d),
        .o_value (o_periods)
    );

    assign o_count    = count_q;
    assign o_wrap     = wrap_q;
    assign o_k_active = k_eff;

endmodule
